// File: rtl/aes_pkg.sv
// Shared AES-128 definitions used by the key schedule and the encryption core.
package aes_pkg;

  localparam int unsigned AES_NR = 10;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_rkey_t;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_DONE   = 2'd2
  } ks_state_t;

  // Round constant for rounds 1..10; any other index yields zero.
  function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    aes_rcon = 8'h01;
      4'd2:    aes_rcon = 8'h02;
      4'd3:    aes_rcon = 8'h04;
      4'd4:    aes_rcon = 8'h08;
      4'd5:    aes_rcon = 8'h10;
      4'd6:    aes_rcon = 8'h20;
      4'd7:    aes_rcon = 8'h40;
      4'd8:    aes_rcon = 8'h80;
      4'd9:    aes_rcon = 8'h1b;
      4'd10:   aes_rcon = 8'h36;
      default: aes_rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, shared between key expansion and SubBytes.
module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);

  always_comb begin
    o_s = 8'h00;
    case (i_a)
      8'h00: o_s = 8'h63; 8'h01: o_s = 8'h7c; 8'h02: o_s = 8'h77; 8'h03: o_s = 8'h7b; 8'h04: o_s = 8'hf2; 8'h05: o_s = 8'h6b; 8'h06: o_s = 8'h6f; 8'h07: o_s = 8'hc5;
      8'h08: o_s = 8'h30; 8'h09: o_s = 8'h01; 8'h0a: o_s = 8'h67; 8'h0b: o_s = 8'h2b; 8'h0c: o_s = 8'hfe; 8'h0d: o_s = 8'hd7; 8'h0e: o_s = 8'hab; 8'h0f: o_s = 8'h76;
      8'h10: o_s = 8'hca; 8'h11: o_s = 8'h82; 8'h12: o_s = 8'hc9; 8'h13: o_s = 8'h7d; 8'h14: o_s = 8'hfa; 8'h15: o_s = 8'h59; 8'h16: o_s = 8'h47; 8'h17: o_s = 8'hf0;
      8'h18: o_s = 8'had; 8'h19: o_s = 8'hd4; 8'h1a: o_s = 8'ha2; 8'h1b: o_s = 8'haf; 8'h1c: o_s = 8'h9c; 8'h1d: o_s = 8'ha4; 8'h1e: o_s = 8'h72; 8'h1f: o_s = 8'hc0;
      8'h20: o_s = 8'hb7; 8'h21: o_s = 8'hfd; 8'h22: o_s = 8'h93; 8'h23: o_s = 8'h26; 8'h24: o_s = 8'h36; 8'h25: o_s = 8'h3f; 8'h26: o_s = 8'hf7; 8'h27: o_s = 8'hcc;
      8'h28: o_s = 8'h34; 8'h29: o_s = 8'ha5; 8'h2a: o_s = 8'he5; 8'h2b: o_s = 8'hf1; 8'h2c: o_s = 8'h71; 8'h2d: o_s = 8'hd8; 8'h2e: o_s = 8'h31; 8'h2f: o_s = 8'h15;
      8'h30: o_s = 8'h04; 8'h31: o_s = 8'hc7; 8'h32: o_s = 8'h23; 8'h33: o_s = 8'hc3; 8'h34: o_s = 8'h18; 8'h35: o_s = 8'h96; 8'h36: o_s = 8'h05; 8'h37: o_s = 8'h9a;
      8'h38: o_s = 8'h07; 8'h39: o_s = 8'h12; 8'h3a: o_s = 8'h80; 8'h3b: o_s = 8'he2; 8'h3c: o_s = 8'heb; 8'h3d: o_s = 8'h27; 8'h3e: o_s = 8'hb2; 8'h3f: o_s = 8'h75;
      8'h40: o_s = 8'h09; 8'h41: o_s = 8'h83; 8'h42: o_s = 8'h2c; 8'h43: o_s = 8'h1a; 8'h44: o_s = 8'h1b; 8'h45: o_s = 8'h6e; 8'h46: o_s = 8'h5a; 8'h47: o_s = 8'ha0;
      8'h48: o_s = 8'h52; 8'h49: o_s = 8'h3b; 8'h4a: o_s = 8'hd6; 8'h4b: o_s = 8'hb3; 8'h4c: o_s = 8'h29; 8'h4d: o_s = 8'he3; 8'h4e: o_s = 8'h2f; 8'h4f: o_s = 8'h84;
      8'h50: o_s = 8'h53; 8'h51: o_s = 8'hd1; 8'h52: o_s = 8'h00; 8'h53: o_s = 8'hed; 8'h54: o_s = 8'h20; 8'h55: o_s = 8'hfc; 8'h56: o_s = 8'hb1; 8'h57: o_s = 8'h5b;
      8'h58: o_s = 8'h6a; 8'h59: o_s = 8'hcb; 8'h5a: o_s = 8'hbe; 8'h5b: o_s = 8'h39; 8'h5c: o_s = 8'h4a; 8'h5d: o_s = 8'h4c; 8'h5e: o_s = 8'h58; 8'h5f: o_s = 8'hcf;
      8'h60: o_s = 8'hd0; 8'h61: o_s = 8'hef; 8'h62: o_s = 8'haa; 8'h63: o_s = 8'hfb; 8'h64: o_s = 8'h43; 8'h65: o_s = 8'h4d; 8'h66: o_s = 8'h33; 8'h67: o_s = 8'h85;
      8'h68: o_s = 8'h45; 8'h69: o_s = 8'hf9; 8'h6a: o_s = 8'h02; 8'h6b: o_s = 8'h7f; 8'h6c: o_s = 8'h50; 8'h6d: o_s = 8'h3c; 8'h6e: o_s = 8'h9f; 8'h6f: o_s = 8'ha8;
      8'h70: o_s = 8'h51; 8'h71: o_s = 8'ha3; 8'h72: o_s = 8'h40; 8'h73: o_s = 8'h8f; 8'h74: o_s = 8'h92; 8'h75: o_s = 8'h9d; 8'h76: o_s = 8'h38; 8'h77: o_s = 8'hf5;
      8'h78: o_s = 8'hbc; 8'h79: o_s = 8'hb6; 8'h7a: o_s = 8'hda; 8'h7b: o_s = 8'h21; 8'h7c: o_s = 8'h10; 8'h7d: o_s = 8'hff; 8'h7e: o_s = 8'hf3; 8'h7f: o_s = 8'hd2;
      8'h80: o_s = 8'hcd; 8'h81: o_s = 8'h0c; 8'h82: o_s = 8'h13; 8'h83: o_s = 8'hec; 8'h84: o_s = 8'h5f; 8'h85: o_s = 8'h97; 8'h86: o_s = 8'h44; 8'h87: o_s = 8'h17;
      8'h88: o_s = 8'hc4; 8'h89: o_s = 8'ha7; 8'h8a: o_s = 8'h7e; 8'h8b: o_s = 8'h3d; 8'h8c: o_s = 8'h64; 8'h8d: o_s = 8'h5d; 8'h8e: o_s = 8'h19; 8'h8f: o_s = 8'h73;
      8'h90: o_s = 8'h60; 8'h91: o_s = 8'h81; 8'h92: o_s = 8'h4f; 8'h93: o_s = 8'hdc; 8'h94: o_s = 8'h22; 8'h95: o_s = 8'h2a; 8'h96: o_s = 8'h90; 8'h97: o_s = 8'h88;
      8'h98: o_s = 8'h46; 8'h99: o_s = 8'hee; 8'h9a: o_s = 8'hb8; 8'h9b: o_s = 8'h14; 8'h9c: o_s = 8'hde; 8'h9d: o_s = 8'h5e; 8'h9e: o_s = 8'h0b; 8'h9f: o_s = 8'hdb;
      8'ha0: o_s = 8'he0; 8'ha1: o_s = 8'h32; 8'ha2: o_s = 8'h3a; 8'ha3: o_s = 8'h0a; 8'ha4: o_s = 8'h49; 8'ha5: o_s = 8'h06; 8'ha6: o_s = 8'h24; 8'ha7: o_s = 8'h5c;
      8'ha8: o_s = 8'hc2; 8'ha9: o_s = 8'hd3; 8'haa: o_s = 8'hac; 8'hab: o_s = 8'h62; 8'hac: o_s = 8'h91; 8'had: o_s = 8'h95; 8'hae: o_s = 8'he4; 8'haf: o_s = 8'h79;
      8'hb0: o_s = 8'he7; 8'hb1: o_s = 8'hc8; 8'hb2: o_s = 8'h37; 8'hb3: o_s = 8'h6d; 8'hb4: o_s = 8'h8d; 8'hb5: o_s = 8'hd5; 8'hb6: o_s = 8'h4e; 8'hb7: o_s = 8'ha9;
      8'hb8: o_s = 8'h6c; 8'hb9: o_s = 8'h56; 8'hba: o_s = 8'hf4; 8'hbb: o_s = 8'hea; 8'hbc: o_s = 8'h65; 8'hbd: o_s = 8'h7a; 8'hbe: o_s = 8'hae; 8'hbf: o_s = 8'h08;
      8'hc0: o_s = 8'hba; 8'hc1: o_s = 8'h78; 8'hc2: o_s = 8'h25; 8'hc3: o_s = 8'h2e; 8'hc4: o_s = 8'h1c; 8'hc5: o_s = 8'ha6; 8'hc6: o_s = 8'hb4; 8'hc7: o_s = 8'hc6;
      8'hc8: o_s = 8'he8; 8'hc9: o_s = 8'hdd; 8'hca: o_s = 8'h74; 8'hcb: o_s = 8'h1f; 8'hcc: o_s = 8'h4b; 8'hcd: o_s = 8'hbd; 8'hce: o_s = 8'h8b; 8'hcf: o_s = 8'h8a;
      8'hd0: o_s = 8'h70; 8'hd1: o_s = 8'h3e; 8'hd2: o_s = 8'hb5; 8'hd3: o_s = 8'h66; 8'hd4: o_s = 8'h48; 8'hd5: o_s = 8'h03; 8'hd6: o_s = 8'hf6; 8'hd7: o_s = 8'h0e;
      8'hd8: o_s = 8'h61; 8'hd9: o_s = 8'h35; 8'hda: o_s = 8'h57; 8'hdb: o_s = 8'hb9; 8'hdc: o_s = 8'h86; 8'hdd: o_s = 8'hc1; 8'hde: o_s = 8'h1d; 8'hdf: o_s = 8'h9e;
      8'he0: o_s = 8'he1; 8'he1: o_s = 8'hf8; 8'he2: o_s = 8'h98; 8'he3: o_s = 8'h11; 8'he4: o_s = 8'h69; 8'he5: o_s = 8'hd9; 8'he6: o_s = 8'h8e; 8'he7: o_s = 8'h94;
      8'he8: o_s = 8'h9b; 8'he9: o_s = 8'h1e; 8'hea: o_s = 8'h87; 8'heb: o_s = 8'he9; 8'hec: o_s = 8'hce; 8'hed: o_s = 8'h55; 8'hee: o_s = 8'h28; 8'hef: o_s = 8'hdf;
      8'hf0: o_s = 8'h8c; 8'hf1: o_s = 8'ha1; 8'hf2: o_s = 8'h89; 8'hf3: o_s = 8'h0d; 8'hf4: o_s = 8'hbf; 8'hf5: o_s = 8'he6; 8'hf6: o_s = 8'h42; 8'hf7: o_s = 8'h68;
      8'hf8: o_s = 8'h41; 8'hf9: o_s = 8'h99; 8'hfa: o_s = 8'h2d; 8'hfb: o_s = 8'h0f; 8'hfc: o_s = 8'hb0; 8'hfd: o_s = 8'h54; 8'hfe: o_s = 8'hbb; 8'hff: o_s = 8'h16;
      default: o_s = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry
// register file, read back through a registered round-index port.
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] key,
  input  logic         init,
  output logic         ready,
  input  logic [3:0]   round_idx,
  output logic [127:0] round_key
);

  ks_state_t r_state, w_next_state;
  logic [3:0] r_rnd;
  aes_rkey_t  r_work;
  aes_rkey_t  r_rk [0:AES_NR];
  aes_rkey_t  r_round_key;

  aes_word_t  w_rot, w_sub, w_t;
  aes_word_t  w_w0, w_w1, w_w2, w_w3;
  aes_rkey_t  w_next_key;
  logic       w_expand;

  assign w_rot = {r_work[23:0], r_work[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_a (w_rot[8*g +: 8]),
      .o_s (w_sub[8*g +: 8])
    );
  end

  assign w_t        = w_sub ^ {aes_rcon(r_rnd), 24'h0};
  assign w_w0       = r_work[127:96] ^ w_t;
  assign w_w1       = r_work[95:64]  ^ w_w0;
  assign w_w2       = r_work[63:32]  ^ w_w1;
  assign w_w3       = r_work[31:0]   ^ w_w2;
  assign w_next_key = {w_w0, w_w1, w_w2, w_w3};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= KS_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (init) begin
      w_next_state = KS_EXPAND;
    end else begin
      case (r_state)
        KS_EXPAND: if (r_rnd == 4'(AES_NR)) w_next_state = KS_DONE;
        default:   w_next_state = r_state;
      endcase
    end
  end

  // init overrides any expansion in flight, so it gates the round write.
  always_comb begin
    w_expand = (r_state == KS_EXPAND) && !init;
    ready    = (r_state == KS_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rnd  <= '0;
      r_work <= '0;
      for (int unsigned i = 0; i <= AES_NR; i++) r_rk[i] <= '0;
    end else if (init) begin
      r_rnd   <= 4'd1;
      r_work  <= key;
      r_rk[0] <= key;
    end else if (w_expand) begin
      r_rnd  <= r_rnd + 4'd1;
      r_work <= w_next_key;
      for (int unsigned i = 1; i <= AES_NR; i++) begin
        if (r_rnd == 4'(i)) r_rk[i] <= w_next_key;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      r_round_key <= '0;
    else if (round_idx > 4'(AES_NR))   r_round_key <= '0;
    else                               r_round_key <= r_rk[round_idx];
  end

  assign round_key = r_round_key;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule using FIPS-197 key expansion vectors.
module tb_aes_key_schedule;

  logic         clk;
  logic         reset_n;
  logic [127:0] key;
  logic         init;
  logic         ready;
  logic [3:0]   round_idx;
  logic [127:0] round_key;

  int n_pass  = 0;
  int n_total = 0;

  logic [127:0] exp_q [$];

  localparam logic [127:0] K_A1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R2   = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] A1_R9   = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] A1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_C1    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_R1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] C1_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  aes_key_schedule dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key       (key),
    .init      (init),
    .ready     (ready),
    .round_idx (round_idx),
    .round_key (round_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_init(input logic [127:0] k);
    key  = k;
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  // Counts edges after the last init sample until ready is seen; 0 if it never rises.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) begin
        cnt = n;
        break;
      end
    end
  endtask

  task automatic push_read(input logic [3:0] idx, input logic [127:0] e);
    round_idx = idx;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [127:0] e;
    n_total++;
    if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      push_read(4'(i), '0);
      e = exp_q.pop_front();
      n_total++;
      if (round_key !== e) $display("FAIL reset_read[%0d] got=%h exp=%h", i, round_key, e);
      else n_pass++;
    end
  endtask

  task automatic test_idle;
    int highs;
    logic [127:0] e;
    highs = 0;
    for (int i = 0; i < 50; i++) begin
      push_read(4'(i % 16), '0);
      if (ready !== 1'b0) highs++;
      e = exp_q.pop_front();
      n_total++;
      if (round_key !== e) $display("FAIL idle_read[%0d] got=%h exp=%h", i, round_key, e);
      else n_pass++;
    end
    n_total++;
    if (highs !== 0) $display("FAIL idle_ready got=%0d high cycles exp=0", highs);
    else n_pass++;
  endtask

  task automatic test_fips_a1;
    int cnt;
    logic [3:0]   idxs [6];
    logic [127:0] exps [6];
    logic [127:0] e;
    idxs = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd10, 4'd11};
    exps = '{K_A1, A1_R1, A1_R2, A1_R9, A1_R10, 128'h0};
    pulse_init(K_A1);
    n_total++;
    if (ready !== 1'b0) $display("FAIL a1_ready_after_init got=%b exp=0", ready);
    else n_pass++;
    wait_ready(cnt);
    n_total++;
    if (cnt !== 10) $display("FAIL a1_latency got=%0d exp=10", cnt);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      push_read(idxs[i], exps[i]);
      e = exp_q.pop_front();
      n_total++;
      if (round_key !== e) $display("FAIL a1_round[%0d] got=%h exp=%h", idxs[i], round_key, e);
      else n_pass++;
    end
    repeat (20) @(posedge clk);
    #1;
    n_total++;
    if (ready !== 1'b1) $display("FAIL a1_ready_hold got=%b exp=1", ready);
    else n_pass++;
  endtask

  task automatic test_key2_bounds;
    int cnt;
    logic [3:0]   idxs [5];
    logic [127:0] exps [5];
    logic [127:0] e;
    idxs = '{4'd10, 4'd11, 4'd15, 4'd0, 4'd1};
    exps = '{C1_R10, 128'h0, 128'h0, K_C1, C1_R1};
    pulse_init(K_C1);
    n_total++;
    if (ready !== 1'b0) $display("FAIL k2_ready_drop got=%b exp=0", ready);
    else n_pass++;
    wait_ready(cnt);
    n_total++;
    if (cnt !== 10) $display("FAIL k2_latency got=%0d exp=10", cnt);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      push_read(idxs[i], exps[i]);
      e = exp_q.pop_front();
      n_total++;
      if (round_key !== e) $display("FAIL k2_round[%0d] got=%h exp=%h", idxs[i], round_key, e);
      else n_pass++;
    end
  endtask

  task automatic test_reinit;
    int cnt;
    logic [127:0] e;
    pulse_init(K_A1);
    repeat (4) @(posedge clk);
    #1;
    pulse_init(K_C1);
    wait_ready(cnt);
    n_total++;
    if (cnt !== 10) $display("FAIL reinit_latency got=%0d exp=10", cnt);
    else n_pass++;
    push_read(4'd10, C1_R10);
    e = exp_q.pop_front();
    n_total++;
    if (round_key !== e) $display("FAIL reinit_round10 got=%h exp=%h", round_key, e);
    else n_pass++;
    push_read(4'd1, C1_R1);
    e = exp_q.pop_front();
    n_total++;
    if (round_key !== e) $display("FAIL reinit_round1 got=%h exp=%h", round_key, e);
    else n_pass++;
  endtask

  task automatic test_reset_mid_expand;
    int highs;
    logic [127:0] e;
    round_idx = 4'd0;
    pulse_init(K_A1);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if (ready !== 1'b0) $display("FAIL midrst_ready got=%b exp=0", ready);
    else n_pass++;
    n_total++;
    if (round_key !== 128'h0) $display("FAIL midrst_round_key got=%h exp=0", round_key);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      push_read(4'(i % 11), '0);
      if (ready !== 1'b0) highs++;
      e = exp_q.pop_front();
      n_total++;
      if (round_key !== e) $display("FAIL midrst_read[%0d] got=%h exp=%h", i % 11, round_key, e);
      else n_pass++;
    end
    n_total++;
    if (highs !== 0) $display("FAIL midrst_no_ready got=%0d high cycles exp=0", highs);
    else n_pass++;
  endtask

  task automatic test_held_init;
    int cnt;
    logic [127:0] e;
    key  = K_C1;
    init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    init = 1'b0;
    wait_ready(cnt);
    n_total++;
    if (cnt !== 10) $display("FAIL held_latency got=%0d exp=10", cnt);
    else n_pass++;
    push_read(4'd10, C1_R10);
    e = exp_q.pop_front();
    n_total++;
    if (round_key !== e) $display("FAIL held_round10 got=%h exp=%h", round_key, e);
    else n_pass++;
    push_read(4'd0, K_C1);
    e = exp_q.pop_front();
    n_total++;
    if (round_key !== e) $display("FAIL held_round0 got=%h exp=%h", round_key, e);
    else n_pass++;
  endtask

  initial begin
    reset_n   = 1'b0;
    key       = '0;
    init      = 1'b0;
    round_idx = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    test_reset();
    test_idle();
    test_fips_a1();
    test_key2_bounds();
    test_reinit();
    test_reset_mid_expand();
    test_held_init();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
